// File: rtl/spi_rom_loader.sv
// Boot-time program loader: reads LOAD_BYTES bytes from a serial EEPROM
// (SPI mode 0, READ command 0x03) and streams them into the CPU program ROM
// write port. The CPU is held off the ROM for as long as a load is running.
module spi_rom_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LOAD_BYTES = 1024,
    parameter int          CLK_DIV    = 4,
    parameter logic [15:0] EE_BASE    = 16'h0
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic [7:0]            checksum,
    output logic                  spi_cs,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [7:0]            rom_wdata
);

    // The byte counter has one extra bit so a full-depth load can count to 2**ADDR_WIDTH.
    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LOAD_BYTES);
    localparam logic [23:0]       HDR      = {8'h03, EE_BASE};

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_HDR,
        READ,
        CS_HOLD,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        bit_q, bit_d;
    logic [23:0]       hdr_q, hdr_d;
    logic [6:0]        shift_q, shift_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cs_q, cs_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        sum_q, sum_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // One tick marks the end of a half SCK period (or of a CS setup/hold wait).
    logic              tick;
    logic [7:0]        rx_byte;

    assign tick    = (div_q == DIV_LAST);
    assign rx_byte = {shift_q, spi_miso};

    // State register and all registered outputs; reset aborts any load at once.
    // NOTE: clocked state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            hdr_q   <= '0;
            shift_q <= '0;
            count_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            hdr_q   <= hdr_d;
            shift_q <= shift_d;
            count_q <= count_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic for the load sequence.
    // NOTE: every signal gets its hold/default value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        hdr_d   = hdr_q;
        shift_d = shift_q;
        count_d = count_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sum_d   = sum_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE && state_q != DONE) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CS_SETUP;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    sum_d   = '0;
                    count_d = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    mosi_d  = HDR[23];
                    hdr_d   = {HDR[22:0], 1'b0};
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    state_d = SHIFT_HDR;
                end
            end
            SHIFT_HDR: begin
                if (tick) begin
                    if (sck_q) begin
                        // Falling edge: the only place mosi is allowed to move.
                        sck_d = 1'b0;
                        if (bit_q == 5'd23) begin
                            state_d = READ;
                            mosi_d  = 1'b0;
                            bit_d   = '0;
                        end else begin
                            bit_d  = bit_q + 1'b1;
                            mosi_d = hdr_q[23];
                            hdr_d  = {hdr_q[22:0], 1'b0};
                        end
                    end else begin
                        sck_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (tick) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                    end else if (count_q == LAST_CNT) begin
                        // Last byte is in and the low phase is complete: stop clocking.
                        state_d = CS_HOLD;
                    end else begin
                        sck_d   = 1'b1;
                        shift_d = rx_byte[6:0];
                        bit_d   = bit_q + 1'b1;
                        if (bit_q[2:0] == 3'd7) begin
                            we_d    = 1'b1;
                            wdata_d = rx_byte;
                            addr_d  = count_q[ADDR_WIDTH-1:0];
                            sum_d   = sum_q + rx_byte;
                            count_d = count_q + 1'b1;
                            bit_d   = '0;
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign checksum  = sum_q;
    assign spi_cs    = cs_q;
    assign spi_clk   = sck_q;
    assign spi_mosi  = mosi_q;
    assign rom_we    = we_q;
    assign rom_addr  = addr_q;
    assign rom_wdata = wdata_q;

endmodule

// File: tb/tb_spi_rom_loader.sv
// Bench for spi_rom_loader: a small instance (4 bytes, CLK_DIV=2) and a
// full-depth instance (1024 bytes, CLK_DIV=1) share one EEPROM model and
// one protocol monitor; expected writes/checksums come from the EEPROM array.
module tb_spi_rom_loader;

    localparam int AW      = 10;
    localparam int S_BYTES = 4;
    localparam int S_DIV   = 2;
    localparam int B_BYTES = 1024;
    localparam int B_DIV   = 1;

    logic raw_clk = 1'b0;
    logic reset   = 1'b1;
    logic start_s = 1'b0;
    logic start_b = 1'b0;
    logic spi_miso = 1'b0;
    logic sel_big = 1'b0;

    logic s_busy, s_done, s_hold, s_cs, s_sck, s_mosi, s_we;
    logic [7:0] s_sum, s_wdata;
    logic [AW-1:0] s_addr;
    logic b_busy, b_done, b_hold, b_cs, b_sck, b_mosi, b_we;
    logic [7:0] b_sum, b_wdata;
    logic [AW-1:0] b_addr;

    always #5 raw_clk = ~raw_clk;

    spi_rom_loader #(.ADDR_WIDTH(AW), .LOAD_BYTES(S_BYTES), .CLK_DIV(S_DIV), .EE_BASE(16'h0)) u_small (
        .raw_clk(raw_clk), .reset(reset), .start(start_s),
        .busy(s_busy), .done(s_done), .cpu_hold(s_hold), .checksum(s_sum),
        .spi_cs(s_cs), .spi_clk(s_sck), .spi_mosi(s_mosi), .spi_miso(spi_miso),
        .rom_we(s_we), .rom_addr(s_addr), .rom_wdata(s_wdata)
    );

    spi_rom_loader #(.ADDR_WIDTH(AW), .LOAD_BYTES(B_BYTES), .CLK_DIV(B_DIV), .EE_BASE(16'h0)) u_big (
        .raw_clk(raw_clk), .reset(reset), .start(start_b),
        .busy(b_busy), .done(b_done), .cpu_hold(b_hold), .checksum(b_sum),
        .spi_cs(b_cs), .spi_clk(b_sck), .spi_mosi(b_mosi), .spi_miso(spi_miso),
        .rom_we(b_we), .rom_addr(b_addr), .rom_wdata(b_wdata)
    );

    // Signals of whichever instance is under test.
    logic m_busy, m_done, m_hold, m_cs, m_sck, m_mosi, m_we;
    logic [7:0] m_sum, m_wdata;
    logic [AW-1:0] m_addr;
    int cdiv_m;
    assign m_busy  = sel_big ? b_busy  : s_busy;
    assign m_done  = sel_big ? b_done  : s_done;
    assign m_hold  = sel_big ? b_hold  : s_hold;
    assign m_cs    = sel_big ? b_cs    : s_cs;
    assign m_sck   = sel_big ? b_sck   : s_sck;
    assign m_mosi  = sel_big ? b_mosi  : s_mosi;
    assign m_we    = sel_big ? b_we    : s_we;
    assign m_sum   = sel_big ? b_sum   : s_sum;
    assign m_wdata = sel_big ? b_wdata : s_wdata;
    assign m_addr  = sel_big ? b_addr  : s_addr;
    assign cdiv_m  = sel_big ? B_DIV   : S_DIV;

    logic [7:0] ee_mem [0:1023];

    // EEPROM model + protocol monitor, sampled half a cycle away from the DUT edge.
    logic prev_sck = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
    int rises = 0, falls = 0, low_cnt = 0, done_cnt = 0, mon_errs = 0, mon_k = 0;
    logic [23:0] hdr_rx = '0;
    logic [AW+7:0] wr_q [$];

    always @(negedge raw_clk) begin
        if (m_hold !== m_busy) begin
            mon_errs++;
            $display("FAIL hold_eq_busy: cpu_hold=%b busy=%b at %0t", m_hold, m_busy, $time);
        end
        if (prev_sck && m_sck && (m_mosi !== prev_mosi)) begin
            mon_errs++;
            $display("FAIL mosi_stable: mosi moved %b->%b while spi_clk high at %0t", prev_mosi, m_mosi, $time);
        end
        if (prev_cs && !m_cs) begin
            rises = 0; falls = 0; low_cnt = 0; hdr_rx = '0;
        end
        if (!m_cs) begin
            if (!prev_sck && m_sck) begin
                if (rises == 0 && low_cnt < cdiv_m) begin
                    mon_errs++;
                    $display("FAIL cs_setup: cs low %0d cycles before first edge, need %0d", low_cnt, cdiv_m);
                end
                if (rises < 24) hdr_rx = {hdr_rx[22:0], m_mosi};
                rises++;
            end else if (prev_sck && !m_sck) begin
                falls++;
                if (falls >= 24) begin
                    mon_k = falls - 24;
                    spi_miso = ee_mem[(mon_k / 8) % 1024][7 - (mon_k % 8)];
                end
            end else if (!m_sck && rises == 0) begin
                low_cnt++;
            end
        end
        if (m_we === 1'b1) wr_q.push_back({m_addr, m_wdata});
        if (m_done === 1'b1) done_cnt++;
        prev_sck  = m_sck;
        prev_cs   = m_cs;
        prev_mosi = m_mosi;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic pulse_start(input bit big);
        @(negedge raw_clk);
        if (big) start_b = 1'b1; else start_s = 1'b1;
        @(negedge raw_clk);
        start_s = 1'b0;
        start_b = 1'b0;
    endtask

    // Runs one load and checks it against the EEPROM contents.
    task automatic check_load(input bit big, input string tag);
        int n, cdiv, base, d0, lat, exp_lat, got_n;
        bit ok;
        logic [7:0] esum;
        logic [AW-1:0] ea;
        n    = big ? B_BYTES : S_BYTES;
        cdiv = big ? B_DIV : S_DIV;
        base = wr_q.size();
        d0   = done_cnt;
        exp_lat = 1 + cdiv + 2 * cdiv * (24 + 8 * n) + cdiv + 1;
        pulse_start(big);
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < exp_lat + 200; i++) begin
            if (m_done === 1'b1) begin ok = 1'b1; break; end
            @(negedge raw_clk);
            lat++;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, lat);
        end else if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, exp_lat);
        end
        repeat (3) @(negedge raw_clk);
        got_n = wr_q.size() - base;
        vectors++;
        if (got_n !== n) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d, expected %0d", tag, got_n, n);
        end
        esum = '0;
        for (int i = 0; i < n; i++) begin
            esum += ee_mem[i];
            ea = AW'(i);
            if (i < got_n) begin
                vectors++;
                if (wr_q[base + i] !== {ea, ee_mem[i]}) begin
                    miscompares++;
                    $display("FAIL %s write[%0d]: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             tag, i, wr_q[base + i][AW+7:8], wr_q[base + i][7:0], ea, ee_mem[i]);
                end
            end
        end
        vectors++;
        if (m_sum !== esum) begin
            miscompares++;
            $display("FAIL %s checksum: got %0h, expected %0h", tag, m_sum, esum);
        end
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d, expected 1", tag, done_cnt - d0);
        end
        vectors++;
        if (rises !== 24 + 8 * n) begin
            miscompares++;
            $display("FAIL %s sck_rises: got %0d, expected %0d", tag, rises, 24 + 8 * n);
        end
        vectors++;
        if (hdr_rx !== 24'h030000) begin
            miscompares++;
            $display("FAIL %s header: got %06h, expected 030000", tag, hdr_rx);
        end
        ea = AW'(n - 1);
        vectors++;
        if ({m_cs, m_sck, m_busy, m_addr} !== {1'b1, 1'b0, 1'b0, ea}) begin
            miscompares++;
            $display("FAIL %s end_state: got cs=%b sck=%b busy=%b addr=%0h, expected cs=1 sck=0 busy=0 addr=%0h",
                     tag, m_cs, m_sck, m_busy, m_addr, ea);
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({m_cs, m_sck, m_mosi, m_we, m_busy, m_done, m_hold} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 1000000", {m_cs, m_sck, m_mosi, m_we, m_busy, m_done, m_hold});
        end
        vectors++;
        if ({m_sum, m_addr, m_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got sum=%0h addr=%0h wdata=%0h, expected 0", m_sum, m_addr, m_wdata);
        end
        @(negedge raw_clk);
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge raw_clk);
            vectors++;
            if ({m_cs, m_sck, m_we, m_busy} !== 4'b1000) begin
                miscompares++;
                $display("FAIL idle[%0d]: cs/sck/we/busy got %b, expected 1000", i, {m_cs, m_sck, m_we, m_busy});
            end
        end
    endtask

    task automatic test_basic_load();
        ee_mem[0] = 8'hA5; ee_mem[1] = 8'h3C; ee_mem[2] = 8'hFF; ee_mem[3] = 8'h00;
        check_load(1'b0, "basic");
        vectors++;
        if (m_sum !== 8'hE0) begin
            miscompares++;
            $display("FAIL basic_checksum_const: got %0h, expected e0", m_sum);
        end
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < S_BYTES; i++) ee_mem[i] = 8'($urandom);
            check_load(1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        int base, d0, n;
        logic [AW+7:0] first [S_BYTES];
        for (int i = 0; i < S_BYTES; i++) ee_mem[i] = 8'($urandom);
        base = wr_q.size();
        d0 = done_cnt;
        pulse_start(1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (m_done === 1'b1) break;
            if (i % 5 == 2) start_s = 1'b1;
            @(negedge raw_clk);
            start_s = 1'b0;
        end
        repeat (5) @(negedge raw_clk);
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL b2b_done: got %0d done pulses, expected 1", done_cnt - d0);
        end
        n = wr_q.size() - base;
        vectors++;
        if (n !== S_BYTES) begin
            miscompares++;
            $display("FAIL b2b_writes: got %0d, expected %0d", n, S_BYTES);
        end
        for (int i = 0; i < S_BYTES; i++) first[i] = (i < n) ? wr_q[base + i] : '0;
        check_load(1'b0, "reload");
        for (int i = 0; i < S_BYTES; i++) begin
            vectors++;
            if (wr_q[wr_q.size() - S_BYTES + i] !== first[i]) begin
                miscompares++;
                $display("FAIL reload_same[%0d]: got %0h, expected %0h", i, wr_q[wr_q.size() - S_BYTES + i], first[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int base, d0, got;
        bit ok;
        for (int i = 0; i < S_BYTES; i++) ee_mem[i] = 8'($urandom);
        base = wr_q.size();
        d0 = done_cnt;
        pulse_start(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (wr_q.size() - base >= 2) begin ok = 1'b1; break; end
            @(negedge raw_clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL abort_wait: byte 1 never written, got %0d writes", wr_q.size() - base);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({m_cs, m_busy, m_hold, m_we, m_sck} !== 5'b10000) begin
            miscompares++;
            $display("FAIL abort_immediate: cs/busy/hold/we/sck got %b, expected 10000", {m_cs, m_busy, m_hold, m_we, m_sck});
        end
        repeat (3) @(negedge raw_clk);
        reset = 1'b0;
        repeat (200) @(negedge raw_clk);
        got = wr_q.size() - base;
        vectors++;
        if (got !== 2 || done_cnt !== d0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d writes %0d dones, expected 2 writes 0 dones", got, done_cnt - d0);
        end
        check_load(1'b0, "after_abort");
    endtask

    task automatic test_full_load();
        for (int i = 0; i < B_BYTES; i++) ee_mem[i] = 8'(i);
        @(negedge raw_clk);
        sel_big = 1'b1;
        check_load(1'b1, "full");
    endtask

    task automatic test_protocol();
        vectors++;
        if (mon_errs !== 0) begin
            miscompares++;
            $display("FAIL protocol_monitor: got %0d violations, expected 0", mon_errs);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic_load();
        test_random_loads();
        test_back_to_back();
        test_reset_abort();
        test_full_load();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
